// File: rtl/tiny_pkg.sv
// tiny_pkg: shared constants and helpers for the tiny16 output-port slice.
//   WORD_W        core word width, default data width of the port
//   OUT_DEPTH_DEF default FIFO depth
//   ptr_w()       pointer width for a power-of-two depth (never below 1)
package tiny_pkg;

   localparam int WORD_W        = 16;
   localparam int OUT_DEPTH_DEF = 8;

   function automatic int ptr_w(input int depth);
      return (depth > 2) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/tiny_out_port_if.sv
// tiny_out_port_if: CPU write strobe and consumer valid/ready read side.
//   WR_EN/WR_DATA  CPU write strobe and word       (master -> port)
//   WR_FULL        FIFO full                       (port -> master)
//   RD_VALID       FIFO non-empty                  (port -> master)
//   RD_READY       consumer accepts RD_DATA        (master -> port)
//   RD_DATA        head-of-FIFO word, fall-through (port -> master)
interface tiny_out_port_if
   import tiny_pkg::*;
#(
   parameter int WIDTH = WORD_W
);

   logic             WR_EN;
   logic [WIDTH-1:0] WR_DATA;
   logic             WR_FULL;
   logic             RD_VALID;
   logic             RD_READY;
   logic [WIDTH-1:0] RD_DATA;

   modport master (
      output WR_EN, WR_DATA, RD_READY,
      input  WR_FULL, RD_VALID, RD_DATA
   );

   modport slave (
      input  WR_EN, WR_DATA, RD_READY,
      output WR_FULL, RD_VALID, RD_DATA
   );

endinterface

// File: rtl/tiny_fifo_mem.sv
// tiny_fifo_mem: DEPTH x WIDTH register array for the output FIFO.
//   clk           write clock
//   we/waddr/wdata synchronous write port
//   raddr/rdata   asynchronous read port
// Storage has no reset: stale entries are never visible because the
// owner only reads an address while it holds a live word.
module tiny_fifo_mem
   import tiny_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = OUT_DEPTH_DEF,
   parameter int PW    = ptr_w(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [PW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [PW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/tiny_out_port.sv
// tiny_out_port: buffered CPU OUT port. CPU writes are queued in a
// DEPTH-entry FIFO and drained over valid/ready; the last drained word is
// held on OUT and dropped writes set a sticky OVF flag.
//   CLK      clock, rising edge
//   RST      asynchronous active-low reset
//   bus      write strobe / read handshake (tiny_out_port_if.slave)
//   OUT      last popped word, held until the next pop
//   LEVEL    occupancy 0..DEPTH
//   OVF      sticky dropped-write flag
//   CLR_OVF  clears OVF (and DROP_CNT)
//   DROP_CNT saturating dropped-write count
// Optional feature: define TINY_OUT_PORT_DROPCNT_EN to add the DROP_CNT
// port and counter; otherwise CNT_W has no effect.
module tiny_out_port
   import tiny_pkg::*;
#(
   parameter int WIDTH = WORD_W,
   parameter int DEPTH = OUT_DEPTH_DEF,
   parameter int CNT_W = 8
) (
   input  logic                     CLK,
   input  logic                     RST,
   tiny_out_port_if.slave           bus,
   output logic [WIDTH-1:0]         OUT,
   output logic [$clog2(DEPTH):0]   LEVEL,
   output logic                     OVF,
   input  logic                     CLR_OVF
`ifdef TINY_OUT_PORT_DROPCNT_EN
   ,
   output logic [CNT_W-1:0]         DROP_CNT
`endif
);

   localparam int PW = ptr_w(DEPTH);
   localparam int LW = $clog2(DEPTH) + 1;

   if (WIDTH < 1 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || CNT_W < 1) begin : g_param_err
      $error("tiny_out_port: bad WIDTH/DEPTH/CNT_W");
   end

   logic [PW-1:0]    wp_q, wp_d, rp_q, rp_d;
   logic [LW-1:0]    level_q, level_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             ovf_q, ovf_d;
   logic [WIDTH-1:0] rdata;
   logic             full, valid, pop, push, drop;

   // Flags decode registered occupancy only; no path from WR_EN/RD_READY.
   assign full  = (level_q == LW'(DEPTH));
   assign valid = (level_q != '0);

   // A pop frees the slot in the same cycle, so a full FIFO still
   // accepts a write while it is being drained.
   assign pop  = valid & bus.RD_READY;
   assign push = bus.WR_EN & (~full | pop);
   assign drop = bus.WR_EN & full & ~pop;

   tiny_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_mem (
      .clk   (CLK),
      .we    (push),
      .waddr (wp_q),
      .wdata (bus.WR_DATA),
      .raddr (rp_q),
      .rdata (rdata)
   );

   always_comb begin
      wp_d    = wp_q;
      rp_d    = rp_q;
      level_d = level_q;
      out_d   = out_q;
      ovf_d   = ovf_q;
      if (push) wp_d = wp_q + PW'(1);
      if (pop) begin
         rp_d  = rp_q + PW'(1);
         out_d = rdata;
      end
      case ({push, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)         ovf_d = 1'b1;
      else if (CLR_OVF) ovf_d = 1'b0;
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wp_q    <= '0;
         rp_q    <= '0;
         level_q <= '0;
         out_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         level_q <= level_d;
         out_q   <= out_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef TINY_OUT_PORT_DROPCNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (drop) begin
         if (CLR_OVF)         cnt_d = CNT_W'(1);
         else if (~&cnt_q)    cnt_d = cnt_q + CNT_W'(1);
      end else if (CLR_OVF) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign DROP_CNT = cnt_q;
`endif

   assign bus.WR_FULL  = full;
   assign bus.RD_VALID = valid;
   assign bus.RD_DATA  = rdata;
   assign OUT          = out_q;
   assign LEVEL        = level_q;
   assign OVF          = ovf_q;

endmodule

// File: tb/tb_tiny_out_port.sv
// tb_tiny_out_port: directed bench for tiny_out_port (WIDTH 16, DEPTH 8).
// Inputs change and outputs are sampled 1 time unit after the rising edge.
module tb_tiny_out_port;
   import tiny_pkg::*;

   logic        CLK = 1'b0;
   logic        RST;
   logic [15:0] OUT;
   logic [3:0]  LEVEL;
   logic        OVF;
   logic        CLR_OVF;
`ifdef TINY_OUT_PORT_DROPCNT_EN
   logic [7:0]  DROP_CNT;
`endif

   int n_chk = 0;
   int n_err = 0;

   tiny_out_port_if #(.WIDTH(16)) bus ();

   tiny_out_port #(.WIDTH(16), .DEPTH(8), .CNT_W(8)) dut (
      .CLK      (CLK),
      .RST      (RST),
      .bus      (bus),
      .OUT      (OUT),
      .LEVEL    (LEVEL),
      .OVF      (OVF),
      .CLR_OVF  (CLR_OVF)
`ifdef TINY_OUT_PORT_DROPCNT_EN
      ,
      .DROP_CNT (DROP_CNT)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Write words base..base+n-1 with no pop.
   task automatic fill(input int base, input int n);
      bus.RD_READY = 1'b0;
      for (int i = 0; i < n; i++) begin
         bus.WR_EN   = 1'b1;
         bus.WR_DATA = 16'(base + i);
         tick();
      end
      bus.WR_EN = 1'b0;
   endtask

   // Pop n words, expecting base..base+n-1 on RD_DATA then OUT.
   task automatic drain(input string tag, input int base, input int n);
      bus.WR_EN    = 1'b0;
      bus.RD_READY = 1'b1;
      for (int i = 0; i < n; i++) begin
         chk({tag, "_rd"}, 32'(bus.RD_DATA), 32'(base + i));
         tick();
         chk({tag, "_out"}, 32'(OUT), 32'(base + i));
      end
      bus.RD_READY = 1'b0;
   endtask

   initial begin
      bus.WR_EN    = 1'b1;
      bus.WR_DATA  = 16'h1234;
      bus.RD_READY = 1'b0;
      CLR_OVF      = 1'b0;
      RST          = 1'b0;

      // Reset held with a write pending: nothing gets in.
      for (int c = 0; c < 2; c++) begin
         tick();
         chk("rst_level", 32'(LEVEL), 0);
         chk("rst_valid", 32'(bus.RD_VALID), 0);
         chk("rst_out", 32'(OUT), 0);
         chk("rst_ovf", 32'(OVF), 0);
         chk("rst_full", 32'(bus.WR_FULL), 0);
`ifdef TINY_OUT_PORT_DROPCNT_EN
         chk("rst_cnt", 32'(DROP_CNT), 0);
`endif
      end
      bus.WR_EN = 1'b0;
      RST       = 1'b1;
      tick();
      chk("post_rst_level", 32'(LEVEL), 0);
      chk("post_rst_valid", 32'(bus.RD_VALID), 0);

      // Single word, first with RD_READY high while empty (ignored).
      bus.WR_EN    = 1'b1;
      bus.WR_DATA  = 16'hBEEF;
      bus.RD_READY = 1'b1;
      tick();
      bus.WR_EN    = 1'b0;
      bus.RD_READY = 1'b0;
      chk("one_valid", 32'(bus.RD_VALID), 1);
      chk("one_rd", 32'(bus.RD_DATA), 32'hBEEF);
      chk("one_level", 32'(LEVEL), 1);
      chk("one_out_hold", 32'(OUT), 0);
      tick();
      chk("one_level_hold", 32'(LEVEL), 1);
      bus.RD_READY = 1'b1;
      tick();
      bus.RD_READY = 1'b0;
      chk("one_out", 32'(OUT), 32'hBEEF);
      chk("one_level0", 32'(LEVEL), 0);
      chk("one_valid0", 32'(bus.RD_VALID), 0);

      // Fill and overflow.
      fill(1, 8);
      chk("fill_full", 32'(bus.WR_FULL), 1);
      chk("fill_level", 32'(LEVEL), 8);
      chk("fill_ovf", 32'(OVF), 0);
      bus.WR_EN   = 1'b1;
      bus.WR_DATA = 16'd9;
      tick();
      bus.WR_EN = 1'b0;
      chk("drop_ovf", 32'(OVF), 1);
      chk("drop_level", 32'(LEVEL), 8);
`ifdef TINY_OUT_PORT_DROPCNT_EN
      chk("drop_cnt", 32'(DROP_CNT), 1);
`endif
      drain("ovf_drain", 1, 8);
      chk("ovf_drain_level", 32'(LEVEL), 0);
      chk("ovf_sticky", 32'(OVF), 1);
      chk("ovf_final_out", 32'(OUT), 8);

      CLR_OVF = 1'b1;
      tick();
      CLR_OVF = 1'b0;
      chk("clr_ovf", 32'(OVF), 0);
`ifdef TINY_OUT_PORT_DROPCNT_EN
      chk("clr_cnt", 32'(DROP_CNT), 0);
`endif

      // Full with simultaneous push and pop: no drop.
      fill(1, 8);
      bus.WR_EN    = 1'b1;
      bus.WR_DATA  = 16'd9;
      bus.RD_READY = 1'b1;
      tick();
      bus.WR_EN    = 1'b0;
      bus.RD_READY = 1'b0;
      chk("pp_out", 32'(OUT), 1);
      chk("pp_level", 32'(LEVEL), 8);
      chk("pp_ovf", 32'(OVF), 0);
      chk("pp_full", 32'(bus.WR_FULL), 1);
      drain("pp_drain", 2, 8);

      // Wrap-around: hold LEVEL at 3 across 20 writes.
      fill(100, 3);
      bus.RD_READY = 1'b1;
      for (int k = 0; k < 17; k++) begin
         bus.WR_EN   = 1'b1;
         bus.WR_DATA = 16'(103 + k);
         chk("wrap_rd", 32'(bus.RD_DATA), 32'(100 + k));
         tick();
         chk("wrap_out", 32'(OUT), 32'(100 + k));
         chk("wrap_level", 32'(LEVEL), 3);
      end
      bus.WR_EN = 1'b0;
      drain("wrap_drain", 117, 3);
      chk("wrap_empty", 32'(bus.RD_VALID), 0);

      // Mid-operation asynchronous reset.
      fill(200, 5);
      chk("mid_level5", 32'(LEVEL), 5);
      #2;
      RST = 1'b0;
      #1;
      chk("mid_rst_level", 32'(LEVEL), 0);
      chk("mid_rst_out", 32'(OUT), 0);
      chk("mid_rst_valid", 32'(bus.RD_VALID), 0);
      tick();
      RST = 1'b1;
      tick();
      chk("mid_post_level", 32'(LEVEL), 0);

      // Clear together with a drop: set wins.
      fill(1, 8);
      bus.WR_EN   = 1'b1;
      bus.WR_DATA = 16'd77;
      CLR_OVF     = 1'b1;
      tick();
      bus.WR_EN = 1'b0;
      CLR_OVF   = 1'b0;
      chk("clrdrop_ovf", 32'(OVF), 1);
      chk("clrdrop_level", 32'(LEVEL), 8);
`ifdef TINY_OUT_PORT_DROPCNT_EN
      chk("clrdrop_cnt", 32'(DROP_CNT), 1);
      // Saturation: 300 more drops pin the counter at 255.
      bus.WR_EN = 1'b1;
      for (int k = 0; k < 300; k++) tick();
      bus.WR_EN = 1'b0;
      chk("cnt_sat", 32'(DROP_CNT), 255);
`endif
      drain("clrdrop_drain", 1, 8);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
